// File: rtl/dice_seq_tracker.sv
// Tracks a transmitter stepping through the dice successor map, locks after a run of correct
// predictions and flywheels through mispredictions. Optional error counter: DICE_SEQ_TRACKER_ERRCNT_EN.
module dice_seq_tracker #(
  parameter int LOCK_COUNT = 2,
  parameter int MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [2:0] sample,
  output logic       locked,
  output logic       error,
  output logic [2:0] expected,
  output logic [1:0] orbit,
  output logic [1:0] phase,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);
  localparam logic [2:0] MISS_N = 3'(MISS_LIMIT);

  function automatic logic [2:0] succ(input logic [2:0] v);
    logic [2:0] r;
    case (v)
      3'd0:    r = 3'd2;
      3'd1:    r = 3'd7;
      3'd2:    r = 3'd5;
      3'd3:    r = 3'd3;
      3'd4:    r = 3'd1;
      3'd5:    r = 3'd6;
      3'd6:    r = 3'd0;
      3'd7:    r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Returns {orbit, phase} for a value on the successor map.
  function automatic logic [3:0] orbit_phase(input logic [2:0] v);
    logic [3:0] r;
    case (v)
      3'd0:    r = {2'd0, 2'd0};
      3'd2:    r = {2'd0, 2'd1};
      3'd5:    r = {2'd0, 2'd2};
      3'd6:    r = {2'd0, 2'd3};
      3'd1:    r = {2'd1, 2'd0};
      3'd7:    r = {2'd1, 2'd1};
      3'd4:    r = {2'd1, 2'd2};
      3'd3:    r = {2'd2, 2'd0};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_track, w_track_nxt;
  logic [2:0] r_match_cnt, w_match_nxt;
  logic [2:0] r_miss_cnt, w_miss_nxt;
  logic       w_err_nxt;
  logic [2:0] w_pred;
  logic [3:0] w_op_nxt;
  logic       r_locked, r_error;
  logic [2:0] r_expected;
  logic [1:0] r_orbit, r_phase;

  assign w_pred   = succ(r_track);
  assign w_op_nxt = orbit_phase(w_track_nxt);

  // Next-state logic; nothing moves unless a valid sample arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_track_nxt = r_track;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err_nxt   = 1'b0;
    if (sample_valid) begin
      case (r_state)
        HUNT: begin
          w_track_nxt = sample;
          w_match_nxt = 3'd0;
          w_state_nxt = CHECK;
        end
        CHECK: begin
          w_track_nxt = sample;
          if (sample == w_pred) begin
            w_match_nxt = r_match_cnt + 3'd1;
            if (r_match_cnt + 3'd1 == LOCK_N) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = 3'd0;
            end else begin
              w_state_nxt = CHECK;
            end
          end else begin
            w_match_nxt = 3'd0;
          end
        end
        LOCKED: begin
          if (sample == w_pred) begin
            w_track_nxt = sample;
            w_miss_nxt  = 3'd0;
          end else begin
            // Flywheel: assume the transmitter advanced even though we missed it.
            w_err_nxt   = 1'b1;
            w_track_nxt = w_pred;
            w_miss_nxt  = r_miss_cnt + 3'd1;
            if (r_miss_cnt + 3'd1 == MISS_N) begin
              w_state_nxt = HUNT;
            end else begin
              w_state_nxt = LOCKED;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end else begin
      w_err_nxt = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_track     <= 3'd0;
      r_match_cnt <= 3'd0;
      r_miss_cnt  <= 3'd0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_expected  <= 3'd2;
      r_orbit     <= 2'd0;
      r_phase     <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_track     <= w_track_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_error     <= w_err_nxt;
      r_expected  <= succ(w_track_nxt);
      r_orbit     <= (w_state_nxt == LOCKED) ? w_op_nxt[3:2] : 2'd0;
      r_phase     <= (w_state_nxt == LOCKED) ? w_op_nxt[1:0] : 2'd0;
    end
  end

`ifdef DICE_SEQ_TRACKER_ERRCNT_EN
  logic [7:0] r_err_count;

  // Saturating count of error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_err_nxt && (r_err_count != 8'd255)) begin
      r_err_count <= r_err_count + 8'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign locked   = r_locked;
  assign error    = r_error;
  assign expected = r_expected;
  assign orbit    = r_orbit;
  assign phase    = r_phase;

endmodule

// File: tb/tb_dice_seq_tracker.sv
// Scoreboard bench for dice_seq_tracker: a reference model pushes expected outputs per driven
// cycle, popped and compared one clock later, plus directed checks on the key scenarios.
module tb_dice_seq_tracker;

  localparam int LOCK_COUNT = 2;
  localparam int MISS_LIMIT = 2;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [2:0] sample;
  logic       locked;
  logic       error;
  logic [2:0] expected;
  logic [1:0] orbit;
  logic [1:0] phase;
  logic [7:0] err_count;

  typedef struct packed {
    logic       lk;
    logic       er;
    logic [2:0] ex;
    logic [1:0] ob;
    logic [1:0] ph;
    logic [7:0] ec;
  } out_t;

  out_t q[$];

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int         m_st;
  logic [2:0] m_tr;
  int         m_mc;
  int         m_ms;
  logic [7:0] m_ec;
  logic       m_err;

  dice_seq_tracker #(.LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .locked(locked), .error(error), .expected(expected), .orbit(orbit),
    .phase(phase), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] m_succ(input logic [2:0] v);
    logic [2:0] tbl [8];
    tbl = '{3'd2, 3'd7, 3'd5, 3'd3, 3'd1, 3'd6, 3'd0, 3'd4};
    return tbl[v];
  endfunction

  function automatic logic [3:0] m_op(input logic [2:0] v);
    logic [3:0] tbl [8];
    // index = value, entry = {orbit, phase}
    tbl = '{4'b0000, 4'b0100, 4'b0001, 4'b1000, 4'b0110, 4'b0010, 4'b0011, 4'b0101};
    return tbl[v];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic [2:0] s);
    out_t o;
    logic [2:0] p;
    m_err = 1'b0;
    if (r) begin
      m_st = 0; m_tr = 3'd0; m_mc = 0; m_ms = 0; m_ec = 8'd0;
    end else if (v) begin
      p = m_succ(m_tr);
      if (m_st == 0) begin
        m_tr = s; m_mc = 0; m_st = 1;
      end else if (m_st == 1) begin
        m_tr = s;
        if (s == p) begin
          m_mc++;
          if (m_mc == LOCK_COUNT) begin m_st = 2; m_ms = 0; end
        end else begin
          m_mc = 0;
        end
      end else begin
        if (s == p) begin
          m_tr = s; m_ms = 0;
        end else begin
          m_err = 1'b1; m_tr = p; m_ms++;
          if (m_ms == MISS_LIMIT) m_st = 0;
`ifdef DICE_SEQ_TRACKER_ERRCNT_EN
          if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
`endif
        end
      end
    end
    o.lk = (m_st == 2);
    o.er = m_err;
    o.ex = m_succ(m_tr);
    o.ob = o.lk ? m_op(m_tr)[3:2] : 2'd0;
    o.ph = o.lk ? m_op(m_tr)[1:0] : 2'd0;
    o.ec = m_ec;
    q.push_back(o);
  endtask

  // Drive one cycle, advance the clock, then pop and compare the scoreboard entry.
  task automatic step(input logic r, input logic v, input logic [2:0] s);
    out_t e;
    rst = r; sample_valid = v; sample = s;
    model(r, v, s);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++; n_mis++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = q.pop_front();
      chk("locked",    {7'd0, locked},  {7'd0, e.lk});
      chk("error",     {7'd0, error},   {7'd0, e.er});
      chk("expected",  {5'd0, expected}, {5'd0, e.ex});
      chk("orbit",     {6'd0, orbit},   {6'd0, e.ob});
      chk("phase",     {6'd0, phase},   {6'd0, e.ph});
      chk("err_count", err_count,       e.ec);
    end
    rst = 1'b0; sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] ec_exp;
    logic [2:0] s;
    logic       v;
    rst = 1'b1; sample_valid = 1'b0; sample = 3'd0;

    // Reset with valid high: reset must win
    step(1'b1, 1'b1, 3'd5);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_expected", {5'd0, expected}, 8'd2);

    // Lock on 0,2,5
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd2);
    chk("not_yet_locked", {7'd0, locked}, 8'd0);
    step(1'b0, 1'b1, 3'd5);
    chk("lock_locked", {7'd0, locked}, 8'd1);
    chk("lock_expected", {5'd0, expected}, 8'd6);
    chk("lock_orbit", {6'd0, orbit}, 8'd0);
    chk("lock_phase", {6'd0, phase}, 8'd2);

    // Single miss: flywheel keeps lock
    step(1'b0, 1'b1, 3'd7);
    chk("miss_error", {7'd0, error}, 8'd1);
    chk("miss_locked", {7'd0, locked}, 8'd1);
    chk("miss_expected", {5'd0, expected}, 8'd0);
    step(1'b0, 1'b1, 3'd0);
    chk("recover_error", {7'd0, error}, 8'd0);
    step(1'b0, 1'b1, 3'd4);
    chk("after_clear_locked", {7'd0, locked}, 8'd1);
    step(1'b0, 1'b1, 3'd4);
    chk("two_miss_locked", {7'd0, locked}, 8'd0);

    // Two consecutive misses from a fresh reset
    step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd2);
    step(1'b0, 1'b1, 3'd5);
    step(1'b0, 1'b1, 3'd3);
    step(1'b0, 1'b1, 3'd3);
    chk("drop_locked", {7'd0, locked}, 8'd0);
`ifdef DICE_SEQ_TRACKER_ERRCNT_EN
    ec_exp = 8'd2;
`else
    ec_exp = 8'd0;
`endif
    chk("drop_err_count", err_count, ec_exp);

    // 1,7,4,1 with idle gaps carrying junk values
    step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd1);
    step(1'b0, 1'b0, 3'd1);
    step(1'b0, 1'b1, 3'd7);
    step(1'b0, 1'b0, 3'd6);
    step(1'b0, 1'b1, 3'd4);
    step(1'b0, 1'b0, 3'd4);
    step(1'b0, 1'b0, 3'd2);
    chk("orbit1_frozen_locked", {7'd0, locked}, 8'd1);
    step(1'b0, 1'b1, 3'd1);
    chk("orbit1_orbit", {6'd0, orbit}, 8'd1);
    chk("orbit1_phase", {6'd0, phase}, 8'd0);

    // Constant 3 self-loop
    step(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < LOCK_COUNT + 1; i++) step(1'b0, 1'b1, 3'd3);
    chk("three_locked", {7'd0, locked}, 8'd1);
    chk("three_orbit", {6'd0, orbit}, 8'd2);
    chk("three_expected", {5'd0, expected}, 8'd3);

    // Saturation: 150 rounds of relock + two misses = 300 errors
    step(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 150; i++) begin
      for (int j = 0; j < LOCK_COUNT + 1; j++) step(1'b0, 1'b1, 3'd3);
      for (int j = 0; j < MISS_LIMIT; j++) step(1'b0, 1'b1, 3'd0);
    end
`ifdef DICE_SEQ_TRACKER_ERRCNT_EN
    ec_exp = 8'd255;
`else
    ec_exp = 8'd0;
`endif
    chk("sat_err_count", err_count, ec_exp);

    // Mid-lock reset with valid high
    for (int j = 0; j < LOCK_COUNT + 1; j++) step(1'b0, 1'b1, 3'd3);
    step(1'b1, 1'b1, 3'd3);
    chk("midrst_locked", {7'd0, locked}, 8'd0);
    chk("midrst_err_count", err_count, 8'd0);
    chk("midrst_expected", {5'd0, expected}, 8'd2);

    // Random mix biased toward correct predictions
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) != 0) ? m_succ(m_tr) : 3'($urandom_range(0, 7));
      step(1'b0, v, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
